// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: "1010" preamble, MSB-first payload, optional even parity,
// with bit stuffing and a guard bit so the preamble is the only "1010" on the line.
module sync_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int IDLE_GAP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int CW = $clog2(DATA_W + 4);
  localparam int GW = $clog2(IDLE_GAP + 1);

  // State names the phase of the bit the next edge will drive.
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GUARD} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [GW-1:0]     gap, gap_nx;
  logic [2:0]        hist, hist_nx;
  logic              tx_nx, act_nx, done_nx;
  logic              load, shift;
  logic [DATA_W-1:0] sreg;
  logic              par;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      gap        <= '0;
      hist       <= '0;
      tx_bit     <= 1'b0;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      gap        <= gap_nx;
      hist       <= hist_nx;
      tx_bit     <= tx_nx;
      tx_active  <= act_nx;
      frame_done <= done_nx;
    end
  end

  // Payload shifter and running parity carry no reset; load overwrites them.
  always_ff @(posedge clk) begin
    if (load) begin
      sreg <= in_data;
      par  <= 1'b0;
    end else if (shift) begin
      sreg <= sreg << 1;
      par  <= par ^ sreg[DATA_W-1];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gap_nx   = gap;
    hist_nx  = hist;
    tx_nx    = 1'b0;
    act_nx   = tx_active;
    done_nx  = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    in_ready = (state == IDLE) && (gap == GW'(IDLE_GAP));

    case (state)
      IDLE: begin
        act_nx = 1'b0;
        if (in_valid && in_ready) begin
          load     = 1'b1;
          tx_nx    = 1'b1;
          act_nx   = 1'b1;
          cnt_nx   = CW'(1);
          state_nx = SYNC;
        end else if (gap != GW'(IDLE_GAP)) begin
          gap_nx = gap + GW'(1);
        end
      end
      SYNC: begin
        tx_nx = ~cnt[0];
        if (cnt == CW'(3)) begin
          cnt_nx   = CW'(DATA_W - 1);
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (hist == 3'b101) begin
          tx_nx = 1'b1;
        end else begin
          tx_nx = sreg[DATA_W-1];
          shift = 1'b1;
          if (cnt == '0) state_nx = (PARITY_EN != 0) ? PAR : GUARD;
          else           cnt_nx   = cnt - CW'(1);
        end
      end
      PAR: begin
        if (hist == 3'b101) begin
          tx_nx = 1'b1;
        end else begin
          tx_nx    = par;
          state_nx = GUARD;
        end
      end
      GUARD: begin
        // A guard '1' leaves hist at x11, so the following edge always ends the frame.
        if (hist == 3'b101) begin
          tx_nx = 1'b1;
        end else begin
          act_nx   = 1'b0;
          done_nx  = 1'b1;
          gap_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state == IDLE) begin
      if (load) hist_nx = 3'b001;
    end else begin
      hist_nx = {hist[1:0], tx_nx};
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: directed frames, reset abort, and a random word stream on
// parity and no-parity instances, checked against a list-based encoder/decoder model.
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sel;
  logic       rdy1, tx1, act1, done1;
  logic       rdy0, tx0, act0, done0;

  int vectors = 0;
  int miscompares = 0;
  int hits = 0, exp_hits = 0, bad_pos = 0;
  int pos = 0, idle_run = 0, last_gap = 0;
  logic [3:0] line = 4'b0;

  always #5 clk = ~clk;

  sync_frame_tx #(.DATA_W(8), .PARITY_EN(1), .IDLE_GAP(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(rdy1),
    .in_data(in_data), .tx_bit(tx1), .tx_active(act1), .frame_done(done1));

  sync_frame_tx #(.DATA_W(8), .PARITY_EN(0), .IDLE_GAP(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(rdy0),
    .in_data(in_data), .tx_bit(tx0), .tx_active(act0), .frame_done(done0));

  wire rdy  = sel ? rdy1  : rdy0;
  wire tx   = sel ? tx1   : tx0;
  wire act  = sel ? act1  : act0;
  wire done = sel ? done1 : done0;

  // Overlapping "1010" detector on the line, plus idle-run tracking.
  always @(negedge clk) begin
    line = {line[2:0], tx};
    if (act) pos++; else pos = 0;
    if (line == 4'b1010) begin
      hits++;
      if (pos != 4) bad_pos++;
    end
    if (!act) idle_run++;
    else if (pos == 1) begin
      last_gap = idle_run;
      idle_run = 0;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tail101(input bit q[$]);
    int n = q.size();
    if (n < 3) return 1'b0;
    return q[n-3] == 1'b1 && q[n-2] == 1'b0 && q[n-1] == 1'b1;
  endfunction

  // Line image of one frame from the rules: preamble, stuffed payload/parity, guard.
  function automatic void encode(input logic [7:0] d, input bit pe,
                                 output logic [63:0] v, output int n);
    bit q[$];
    bit src[$];
    bit p = 1'b0;
    q = {1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 7; i >= 0; i--) begin
      src.push_back(d[i]);
      p ^= d[i];
    end
    if (pe) src.push_back(p);
    foreach (src[k]) begin
      if (tail101(q)) q.push_back(1'b1);
      q.push_back(src[k]);
    end
    if (tail101(q)) q.push_back(1'b1);
    v = '0;
    foreach (q[k]) v = {v[62:0], q[k]};
    n = q.size();
  endfunction

  // Receiver view: drop preamble and every bit that follows "101".
  function automatic logic [8:0] deser(input bit q[$], input int nbits);
    logic [8:0] r = '0;
    int got = 0;
    for (int i = 4; i < q.size() && got < nbits; i++) begin
      if (q[i-3] == 1'b1 && q[i-2] == 1'b0 && q[i-1] == 1'b1) continue;
      r = {r[7:0], q[i]};
      got++;
    end
    return r;
  endfunction

  task automatic wait_ready;
    int w = 0;
    while (!rdy && w < 50) begin
      step;
      w++;
    end
    if (!rdy) begin
      $display("FAIL ready_timeout: in_ready observed 0 expected 1");
      $fatal(1, "in_ready never rose");
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit hold, input int dly,
                           output logic [63:0] rv, output int rn);
    bit q[$];
    logic [63:0] ev;
    int en;
    bit pe = sel;
    in_valid = 1'b0;
    repeat (dly) step;
    in_data  = d;
    in_valid = 1'b1;
    wait_ready;
    step;
    exp_hits++;
    if (!hold) in_valid = 1'b0;
    in_data = 8'($urandom);
    rv = '0;
    rn = 0;
    while (act && rn < 64) begin
      rv = {rv[62:0], tx};
      q.push_back(tx);
      rn++;
      chk("busy_done_ready", {done, rdy}, 2'b00);
      step;
    end
    if (rn >= 64) begin
      $display("FAIL frame_timeout: tx_active observed 1 expected 0");
      $fatal(1, "frame never ended");
    end
    chk("end_done_tx_act", {done, tx, act}, 3'b100);
    encode(d, pe, ev, en);
    chk("frame_len", 64'(rn), 64'(en));
    chk("frame_bits", rv, ev);
    chk("deser_word", deser(q, pe ? 9 : 8), pe ? {d, ^d} : {1'b0, d});
    step;
    chk("done_pulse_width", done, 1'b0);
  endtask

  initial begin
    logic [63:0] rv;
    int rn;
    sel = 1'b1;
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;

    repeat (3) begin
      step;
      chk("reset_state", {tx, act, done, rdy}, 4'b0000);
    end
    reset = 1'b0;
    chk("gap_cycle0", rdy, 1'b0);
    step;
    chk("gap_cycle1", rdy, 1'b0);
    step;
    chk("gap_cycle2", rdy, 1'b1);

    run_frame(8'hA5, 1'b0, 0, rv, rn);
    chk("a5_len", 64'(rn), 64'd16);
    chk("a5_bits", rv, 64'hAD96);

    run_frame(8'h02, 1'b0, 0, rv, rn);
    chk("02_len", 64'(rn), 64'd14);
    chk("02_bits", rv, 64'h280B);

    run_frame(8'hFF, 1'b1, 0, rv, rn);
    run_frame(8'h00, 1'b0, 0, rv, rn);
    chk("b2b_idle_gap", 64'(last_gap), 64'd3);
    chk("b2b_hits", 64'(hits), 64'(exp_hits));

    // Abort an A5 frame on its 7th active cycle.
    in_data = 8'hA5;
    in_valid = 1'b1;
    wait_ready;
    step;
    in_valid = 1'b0;
    exp_hits++;
    rv = '0;
    for (int k = 0; k < 7; k++) begin
      rv = {rv[62:0], tx};
      if (k < 6) step;
    end
    chk("abort_prefix", rv, 64'b1010110);
    reset = 1'b1;
    step;
    chk("abort_line", {tx, act, done}, 3'b000);
    reset = 1'b0;
    chk("abort_gap0", {rdy, done}, 2'b00);
    step;
    chk("abort_gap1", {rdy, done}, 2'b00);
    step;
    chk("abort_gap2", {rdy, done}, 2'b10);
    run_frame(8'hA5, 1'b0, 0, rv, rn);
    chk("after_abort_bits", rv, 64'hAD96);

    for (int s = 1; s >= 0; s--) begin
      sel = s[0];
      repeat (4) step;
      for (int i = 0; i < 500; i++)
        run_frame(8'($urandom), 1'b0, int'($urandom_range(0, 3)), rv, rn);
    end

    repeat (4) step;
    chk("total_hits", 64'(hits), 64'(exp_hits));
    chk("hit_position", 64'(bad_pos), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
